// File: rtl/mips_mem_pkg.sv
// Shared encodings and helpers for the memory stage: access sizes, FSM states,
// the EX/MEM slot layout and the alignment rule used by both capture and issue.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  size;
        logic        uns;
        logic        reg_write;
        logic        mem_to_reg;
        logic        and_out;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [4:0]  wreg;
        logic [31:0] target;
    } exmem_t;

    // Counter must hold TIMEOUT-1.
    function automatic int tmo_cnt_w(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

    // Size 2'b11 is treated as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte enables / replicated write data,
// and load byte/half extraction with sign or zero extension.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_HALF: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_ld_data = i_rdata;
        case (i_size)
            SZ_BYTE: o_ld_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM slot, req/ack data-memory FSM with timeout,
// MEM/WB register and registered branch decision for PC select.
module mem_stage
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int REG_LEN = 32   // only 32 is supported
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               flush,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [1:0]         mem_size,
    input  logic               mem_unsigned,
    input  logic               reg_write,
    input  logic               mem_to_reg,
    input  logic               and_out,
    input  logic [REG_LEN-1:0] alu_result,
    input  logic [REG_LEN-1:0] rt_data,
    input  logic [4:0]         write_reg,
    input  logic [REG_LEN-1:0] adder_jump_addr_imm,
    output logic               stall_out,
    output logic               pc_src,
    output logic [REG_LEN-1:0] branch_target,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [REG_LEN-1:0] dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [REG_LEN-1:0] dmem_wdata,
    input  logic               dmem_ack,
    input  logic [REG_LEN-1:0] dmem_rdata,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [4:0]         wb_write_reg,
    output logic [REG_LEN-1:0] wb_alu_result,
    output logic [REG_LEN-1:0] wb_load_data,
    output logic               wb_misalign,
    output logic               wb_bus_error
);

    localparam int            CW      = tmo_cnt_w(TIMEOUT);
    localparam logic [CW-1:0] HIT_VAL = CW'(TIMEOUT - 1);

    mem_state_t    r_state, w_next;
    exmem_t        r_ex, w_ex_in;
    logic [CW-1:0] r_cnt;

    logic          r_wb_valid, r_wb_reg_write, r_wb_mem_to_reg, r_wb_misalign, r_wb_bus_error;
    logic [4:0]    r_wb_write_reg;
    logic [31:0]   r_wb_alu_result, r_wb_load_data;

    logic          w_capture, w_ack, w_tmo, w_memop, w_mis_op, w_in_memop;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_ld_data;

    assign w_ex_in = '{
        valid:      ex_valid & ~flush,
        mem_read:   mem_read,
        mem_write:  mem_write,
        size:       mem_size,
        uns:        mem_unsigned,
        reg_write:  reg_write,
        mem_to_reg: mem_to_reg,
        and_out:    and_out,
        alu:        alu_result,
        rt:         rt_data,
        wreg:       write_reg,
        target:     adder_jump_addr_imm
    };

    assign w_capture  = ~stall_out;
    assign w_memop    = r_ex.valid & (r_ex.mem_read | r_ex.mem_write);
    assign w_mis_op   = w_memop & is_misaligned(r_ex.size, r_ex.alu[1:0]);
    // Decides the FSM transition on the edge that captures the incoming slot.
    assign w_in_memop = w_ex_in.valid & (mem_read | mem_write)
                      & ~is_misaligned(mem_size, alu_result[1:0]);

    mem_lane_align u_align (
        .i_size     (r_ex.size),
        .i_addr_lo  (r_ex.alu[1:0]),
        .i_unsigned (r_ex.uns),
        .i_st_data  (r_ex.rt),
        .i_rdata    (dmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_in_memop) w_next = REQ;
            REQ:     if (w_ack | w_tmo) w_next = w_in_memop ? REQ : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        dmem_req  = 1'b0;
        stall_out = 1'b0;
        w_ack     = 1'b0;
        w_tmo     = 1'b0;
        if (r_state == REQ) begin
            dmem_req  = 1'b1;
            w_ack     = dmem_ack;
            w_tmo     = ~dmem_ack & (r_cnt == HIT_VAL);
            stall_out = ~dmem_ack & (r_cnt != HIT_VAL);
        end
    end

    assign dmem_we    = dmem_req & r_ex.mem_write;
    assign dmem_addr  = dmem_req ? {r_ex.alu[31:2], 2'b00} : '0;
    assign dmem_be    = dmem_req ? w_be : 4'b0000;
    assign dmem_wdata = dmem_req ? w_wdata : '0;

    // Counts stalled REQ cycles; any completion (ack or timeout) restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (stall_out) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= '0;
        end else if (w_capture) begin
            r_ex <= w_ex_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid      <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_misalign   <= 1'b0;
            r_wb_bus_error  <= 1'b0;
            r_wb_write_reg  <= '0;
            r_wb_alu_result <= '0;
            r_wb_load_data  <= '0;
        end else if (w_capture && r_ex.valid) begin
            r_wb_valid      <= 1'b1;
            r_wb_reg_write  <= r_ex.reg_write & ~w_mis_op & ~w_tmo;
            r_wb_mem_to_reg <= r_ex.mem_to_reg;
            r_wb_misalign   <= w_mis_op;
            r_wb_bus_error  <= w_tmo;
            r_wb_write_reg  <= r_ex.wreg;
            r_wb_alu_result <= r_ex.alu;
            r_wb_load_data  <= (w_ack & r_ex.mem_read) ? w_ld_data : '0;
        end else begin
            r_wb_valid      <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_mem_to_reg <= 1'b0;
            r_wb_misalign   <= 1'b0;
            r_wb_bus_error  <= 1'b0;
            r_wb_write_reg  <= '0;
            r_wb_alu_result <= '0;
            r_wb_load_data  <= '0;
        end
    end

    assign pc_src        = r_ex.valid & r_ex.and_out;
    assign branch_target = r_ex.target;

    assign wb_valid      = r_wb_valid;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_mem_to_reg = r_wb_mem_to_reg;
    assign wb_write_reg  = r_wb_write_reg;
    assign wb_alu_result = r_wb_alu_result;
    assign wb_load_data  = r_wb_load_data;
    assign wb_misalign   = r_wb_misalign;
    assign wb_bus_error  = r_wb_bus_error;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written multi-cycle
// sequences, then random traffic against a byte-addressed memory model.
module tb_mem_stage;
    import mips_mem_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, flush, mem_read, mem_write, mem_unsigned, reg_write, mem_to_reg, and_out;
    logic [1:0]  mem_size;
    logic [31:0] alu_result, rt_data, adder_jump_addr_imm;
    logic [4:0]  write_reg;
    logic        stall_out, pc_src, dmem_req, dmem_we, dmem_ack;
    logic [31:0] branch_target, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg, wb_misalign, wb_bus_error;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_alu_result, wb_load_data;

    mem_stage #(.TIMEOUT(TMO), .REG_LEN(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .and_out(and_out), .alu_result(alu_result), .rt_data(rt_data),
        .write_reg(write_reg), .adder_jump_addr_imm(adder_jump_addr_imm),
        .stall_out(stall_out), .pc_src(pc_src), .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_write_reg(wb_write_reg),
        .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
        .wb_misalign(wb_misalign), .wb_bus_error(wb_bus_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v, fl, rd, wr;
        logic [1:0]  sz;
        logic        uns, rw, m2r, br;
        logic [31:0] alu, rt;
        logic [4:0]  wreg;
        logic [31:0] tgt;
    } ins_t;

    typedef struct packed {
        ins_t        ins;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
        logic        e_mis;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] bmem [logic [31:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input ins_t x);
        ex_valid = x.v;   flush = x.fl;   mem_read = x.rd;   mem_write = x.wr;
        mem_size = x.sz;  mem_unsigned = x.uns;  reg_write = x.rw;  mem_to_reg = x.m2r;
        and_out = x.br;   alu_result = x.alu;    rt_data = x.rt;    write_reg = x.wreg;
        adder_jump_addr_imm = x.tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ins_t mkins(input logic rd, input logic wr, input logic [1:0] sz,
                                   input logic uns, input logic [31:0] alu, input logic [31:0] rt);
        ins_t x;
        x = '0;
        x.v = 1'b1; x.rd = rd; x.wr = wr; x.sz = sz; x.uns = uns;
        x.rw = rd; x.m2r = rd; x.alu = alu; x.rt = rt; x.wreg = 5'd9;
        return x;
    endfunction

    function automatic vec_t mkv(input ins_t x, input logic [31:0] rdata, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input logic [31:0] ld, input logic mis);
        vec_t v;
        v.ins = x; v.rdata = rdata; v.e_addr = addr; v.e_be = be;
        v.e_wdata = wdata; v.e_ld = ld; v.e_mis = mis;
        return v;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [7:0] rdb(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : (a[7:0] ^ a[15:8] ^ 8'h3C);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int nb;
        nb = nbytes(sz);
        v = '0;
        for (int j = 0; j < nb; j++) v[8*j +: 8] = rdb(a + 32'(j));
        if (nb == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
        if (nb == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    vec_t vt [13];
    ins_t nop, x, nx, slot;

    initial begin
        nop = '0;
        rst = 1'b1;
        drive(nop);
        dmem_ack = 1'b0;
        dmem_rdata = '0;

        // ---- reset state
        #3;
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_pc_src", pc_src, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_alu", wb_alu_result, 0);
        chk("rst_branch_target", branch_target, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ---- ALU op: one-edge latency, no memory request
        x = '0; x.v = 1'b1; x.rw = 1'b1; x.wreg = 5'd5; x.alu = 32'h0000_1234;
        drive(x);
        tick();
        drive(nop);
        chk("alu_req_slot", dmem_req, 0);
        tick();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_alu", wb_alu_result, 32'h1234);
        chk("alu_wb_rw", wb_reg_write, 1);
        chk("alu_wb_reg", wb_write_reg, 5);
        chk("alu_req_after", dmem_req, 0);

        // ---- table of zero-wait accesses
        vt[0]  = mkv(mkins(1, 0, 2'b00, 0, 32'h103, 0), 32'h80FF_0000, 32'h100, 4'h0, 0, 32'hFFFF_FF80, 0);
        vt[1]  = mkv(mkins(0, 1, 2'b01, 0, 32'h202, 32'h0000_BEEF), 0, 32'h200, 4'hC, 32'hBEEF_BEEF, 0, 0);
        vt[2]  = mkv(mkins(1, 0, 2'b01, 1, 32'h002, 0), 32'h8001_1234, 32'h000, 4'h0, 0, 32'h0000_8001, 0);
        vt[3]  = mkv(mkins(1, 0, 2'b01, 0, 32'h000, 0), 32'h0000_F00F, 32'h000, 4'h0, 0, 32'hFFFF_F00F, 0);
        vt[4]  = mkv(mkins(0, 1, 2'b00, 0, 32'h101, 32'h1234_5678), 0, 32'h100, 4'h2, 32'h7878_7878, 0, 0);
        vt[5]  = mkv(mkins(0, 1, 2'b10, 0, 32'h010, 32'hCAFE_F00D), 0, 32'h010, 4'hF, 32'hCAFE_F00D, 0, 0);
        vt[6]  = mkv(mkins(1, 0, 2'b10, 0, 32'h006, 0), 32'h1111_1111, 0, 4'h0, 0, 0, 1);
        vt[7]  = mkv(mkins(1, 0, 2'b00, 1, 32'h102, 0), 32'h0080_0000, 32'h100, 4'h0, 0, 32'h0000_0080, 0);
        vt[8]  = mkv(mkins(1, 0, 2'b01, 0, 32'h003, 0), 32'h2222_2222, 0, 4'h0, 0, 0, 1);
        vt[9]  = mkv(mkins(1, 0, 2'b11, 0, 32'h008, 0), 32'hDEAD_BEEF, 32'h008, 4'h0, 0, 32'hDEAD_BEEF, 0);
        vt[10] = mkv(mkins(0, 1, 2'b10, 0, 32'h021, 32'h5555_AAAA), 0, 0, 4'h0, 0, 0, 1);
        vt[11] = mkv(mkins(1, 0, 2'b00, 0, 32'h100, 0), 32'h0000_007F, 32'h100, 4'h0, 0, 32'h0000_007F, 0);
        vt[12] = mkv(mkins(0, 1, 2'b00, 0, 32'h103, 32'h0000_00AB), 0, 32'h100, 4'h8, 32'hABAB_ABAB, 0, 0);

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].ins);
            tick();
            drive(nop);
            dmem_ack = 1'b1;
            dmem_rdata = vt[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), dmem_req, !vt[i].e_mis);
            chk($sformatf("v%0d_stall", i), stall_out, 0);
            if (!vt[i].e_mis) begin
                chk($sformatf("v%0d_addr", i), dmem_addr, vt[i].e_addr);
                chk($sformatf("v%0d_we", i), dmem_we, vt[i].ins.wr);
                if (vt[i].ins.wr) begin
                    chk($sformatf("v%0d_be", i), dmem_be, vt[i].e_be);
                    chk($sformatf("v%0d_wdata", i), dmem_wdata, vt[i].e_wdata);
                end
            end
            tick();
            dmem_ack = 1'b0;
            chk($sformatf("v%0d_wb_valid", i), wb_valid, 1);
            chk($sformatf("v%0d_wb_mis", i), wb_misalign, vt[i].e_mis);
            chk($sformatf("v%0d_wb_rw", i), wb_reg_write, vt[i].ins.rw & !vt[i].e_mis);
            if (vt[i].ins.rd && !vt[i].e_mis)
                chk($sformatf("v%0d_wb_ld", i), wb_load_data, vt[i].e_ld);
        end

        // ---- load word with ack after 3 wait cycles; new op driven during stall
        drive(mkins(1, 0, 2'b10, 0, 32'h40, 0));
        tick();
        x = '0; x.v = 1'b1; x.rw = 1'b1; x.wreg = 5'd7; x.alu = 32'hFFFF_FFF0;
        drive(x);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("wait_stall", stall_out, 1);
            chk("wait_req", dmem_req, 1);
            chk("wait_addr_held", dmem_addr, 32'h40);
            tick();
            chk("wait_bubble", wb_valid, 0);
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1122_3344;
        #1;
        chk("wait_ack_stall", stall_out, 0);
        tick();
        dmem_ack = 1'b0;
        drive(nop);
        chk("wait_wb_valid", wb_valid, 1);
        chk("wait_wb_ld", wb_load_data, 32'h1122_3344);
        chk("wait_wb_alu", wb_alu_result, 32'h40);
        tick();
        chk("wait_next_valid", wb_valid, 1);
        chk("wait_next_alu", wb_alu_result, 32'hFFFF_FFF0);

        // ---- never-acked load: bus error after TMO request cycles
        begin
            int reqc;
            int cyc;
            reqc = 0;
            cyc = 0;
            drive(mkins(1, 0, 2'b10, 0, 32'h80, 0));
            tick();
            drive(nop);
            while (!wb_valid && cyc < 40) begin
                #1;
                if (dmem_req) reqc++;
                tick();
                cyc++;
            end
            chk("tmo_in_time", (cyc < 40) ? 1 : 0, 1);
            chk("tmo_req_cycles", reqc, TMO);
            chk("tmo_bus_error", wb_bus_error, 1);
            chk("tmo_reg_write", wb_reg_write, 0);
            dmem_ack = 1'b1;
            #1;
            chk("late_ack_req", dmem_req, 0);
            chk("late_ack_stall", stall_out, 0);
            tick();
            dmem_ack = 1'b0;
            chk("late_ack_wb", wb_valid, 0);
        end

        // ---- reset during REQ
        drive(mkins(1, 0, 2'b10, 0, 32'h90, 0));
        tick();
        drive(nop);
        chk("rreq_req", dmem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rreq_req_drop", dmem_req, 0);
        chk("rreq_stall", stall_out, 0);
        chk("rreq_wb_valid", wb_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rreq_no_wb", wb_valid, 0);

        // ---- flushed branch must not redirect; real branch does
        x = '0; x.v = 1'b1; x.fl = 1'b1; x.br = 1'b1; x.tgt = 32'h4000;
        drive(x);
        tick();
        chk("flush_pc_src", pc_src, 0);
        x.fl = 1'b0; x.tgt = 32'h5000;
        drive(x);
        tick();
        chk("br_pc_src", pc_src, 1);
        chk("br_target", branch_target, 32'h5000);
        drive(nop);
        tick();
        tick();
        tick();

        // ---- random traffic against the memory model
        begin
            int slot_n, slot_L, nb;
            logic amem, ack, ex_stall, aligned, tmo;
            logic e_valid, e_rw, e_m2r, e_mis, e_berr, e_ldchk;
            logic [4:0]  e_wreg;
            logic [31:0] e_alu, e_ld, base, word, ew;
            logic [3:0]  ebe;
            slot = '0;
            slot_n = 0;
            slot_L = 0;
            e_valid = 0; e_rw = 0; e_m2r = 0; e_mis = 0; e_berr = 0; e_ldchk = 0;
            e_wreg = '0; e_alu = '0; e_ld = '0;
            for (int cyc = 0; cyc < 500; cyc++) begin
                chk("r_wb_valid", wb_valid, e_valid);
                chk("r_wb_rw", wb_reg_write, e_rw);
                chk("r_wb_mis", wb_misalign, e_mis);
                chk("r_wb_berr", wb_bus_error, e_berr);
                chk("r_wb_m2r", wb_mem_to_reg, e_m2r);
                if (e_valid) begin
                    chk("r_wb_reg", wb_write_reg, e_wreg);
                    chk("r_wb_alu", wb_alu_result, e_alu);
                end
                if (e_ldchk) chk("r_wb_ld", wb_load_data, e_ld);
                chk("r_pc_src", pc_src, slot.v & slot.br);
                chk("r_target", branch_target, slot.tgt);

                nb = nbytes(slot.sz);
                aligned = (slot.alu % nb) == 0;
                amem = slot.v & (slot.rd | slot.wr) & aligned;
                base = {slot.alu[31:2], 2'b00};
                word = {rdb(base + 3), rdb(base + 2), rdb(base + 1), rdb(base)};
                ack = amem ? (slot_n == slot_L) : ($urandom % 4 == 0);
                dmem_ack = ack;
                dmem_rdata = amem ? word : $urandom;
                #1;
                chk("r_req", dmem_req, amem);
                if (amem) begin
                    chk("r_addr", dmem_addr, base);
                    chk("r_we", dmem_we, slot.wr);
                    if (slot.wr) begin
                        for (int i = 0; i < 4; i++) begin
                            ebe[i] = (base + 32'(i) >= slot.alu) && (base + 32'(i) < slot.alu + 32'(nb));
                            ew[8*i +: 8] = slot.rt[8*(i % nb) +: 8];
                        end
                        chk("r_be", dmem_be, ebe);
                        chk("r_wdata", dmem_wdata, ew);
                    end
                end
                ex_stall = amem && (slot_n < slot_L) && (slot_n < TMO - 1);
                chk("r_stall", stall_out, ex_stall);

                if (ex_stall || !slot.v) begin
                    e_valid = 0; e_rw = 0; e_m2r = 0; e_mis = 0; e_berr = 0; e_ldchk = 0;
                end else begin
                    tmo = amem & !ack;
                    e_valid = 1;
                    e_mis = (slot.rd | slot.wr) & !aligned;
                    e_berr = tmo;
                    e_rw = slot.rw & !e_mis & !tmo;
                    e_m2r = slot.m2r;
                    e_wreg = slot.wreg;
                    e_alu = slot.alu;
                    e_ldchk = amem & slot.rd & ack;
                    if (e_ldchk) e_ld = model_load(slot.alu, slot.sz, slot.uns);
                    if (amem && slot.wr && ack)
                        for (int j = 0; j < nb; j++) bmem[slot.alu + 32'(j)] = slot.rt[8*j +: 8];
                end

                nx = '0;
                nx.v = ($urandom % 8) != 0;
                nx.fl = ($urandom % 8) == 0;
                case ($urandom % 3)
                    0: ;
                    1: nx.rd = 1'b1;
                    default: nx.wr = 1'b1;
                endcase
                nx.sz = 2'($urandom % 4);
                nx.uns = 1'($urandom);
                nx.rw = 1'($urandom);
                nx.m2r = 1'($urandom);
                nx.br = 1'($urandom);
                nx.alu = $urandom_range(0, 63);
                if ($urandom % 4 != 0) nx.alu = nx.alu - (nx.alu % nbytes(nx.sz));
                nx.rt = $urandom;
                nx.wreg = 5'($urandom);
                nx.tgt = $urandom;
                drive(nx);
                if (ex_stall) begin
                    slot_n++;
                end else begin
                    slot = nx;
                    slot.v = nx.v & ~nx.fl;
                    slot_n = 0;
                    case ($urandom % 16)
                        0, 1, 2, 3, 4, 5, 6, 7:     slot_L = 0;
                        8, 9, 10, 11, 12, 13:      slot_L = $urandom_range(1, 4);
                        default:                   slot_L = 20;
                    endcase
                end
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
